// File: rtl/ahb_lite_sram_slave_pkg.sv
// Shared AHB-Lite types and constants for the SRAM slave: transfer encodings,
// response codes, slave FSM states and the byte-lane helper.
package AHBpkg;

  localparam int ADDRWIDTH = 32;
  localparam int DATAWIDTH = 32;

  typedef enum logic [2:0] {
    BYTE     = 3'd0,
    HALFWORD = 3'd1,
    WORD     = 3'd2,
    DWORD    = 3'd3,
    LINE4    = 3'd4,
    LINE8    = 3'd5,
    LINE16   = 3'd6,
    LINE32   = 3'd7
  } HSIZE_TYPE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } HTRANS_TYPE;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } HBURST_TYPE;

  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

  typedef enum logic [1:0] {
    S_OKAY = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } slave_state_t;

  // Little-endian lane enables; data stays on its own lanes, no shifting.
  function automatic logic [3:0] byte_lanes(input HSIZE_TYPE size, input logic [1:0] a);
    case (size)
      BYTE:     return 4'b0001 << a;
      HALFWORD: return a[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_sram_slave_array.sv
// Word-organised storage: byte-enable synchronous write, asynchronous read.
module ahb_sram_array #(
  parameter int DEPTH = 1024,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: address-phase error check, programmable wait states,
// two-cycle ERROR response and byte-lane writes into ahb_sram_array.
module ahb_lite_sram_slave
  import AHBpkg::*;
#(
  parameter int ADDRWIDTH  = AHBpkg::ADDRWIDTH,
  parameter int DATAWIDTH  = AHBpkg::DATAWIDTH,
  parameter int MEMDEPTH   = 1024,
  parameter int WAITSTATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [ADDRWIDTH-1:0] HADDR,
  input  logic                 HWRITE,
  input  HSIZE_TYPE            HSIZE,
  input  HBURST_TYPE           HBURST,
  input  HTRANS_TYPE           HTRANS,
  input  logic [DATAWIDTH-1:0] HWDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic [DATAWIDTH-1:0] HRDATA
);

  localparam int AW = (MEMDEPTH > 1) ? $clog2(MEMDEPTH) : 1;

  slave_state_t  state, state_n;
  logic [3:0]    wcnt, wcnt_n;
  logic [AW+1:0] addr_q;
  logic          write_q;
  HSIZE_TYPE     size_q;
  logic          valid_q;

  logic          xfer;
  logic          addr_err;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   mem_rdata;
  logic          unused_burst;

  assign unused_burst = ^HBURST;

  assign xfer = (HTRANS == NONSEQ) || (HTRANS == SEQ);

  // Decided in the address phase so the data phase can start as ERR1 directly.
  assign addr_err = (64'(HADDR) >= 64'(MEMDEPTH) * 64'd4) ||
                    (HSIZE > WORD) ||
                    ((HSIZE == HALFWORD) && HADDR[0]) ||
                    ((HSIZE == WORD) && (HADDR[1:0] != 2'b00));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= S_OKAY;
      wcnt  <= 4'd0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    HREADY  = 1'b1;
    HRESP   = OKAY;
    case (state)
      S_OKAY, S_ERR2: begin
        HRESP = (state == S_ERR2) ? ERROR : OKAY;
        if (xfer && addr_err) begin
          state_n = S_ERR1;
        end else if (xfer && (WAITSTATES > 0)) begin
          state_n = S_WAIT;
          wcnt_n  = 4'(WAITSTATES - 1);
        end else begin
          state_n = S_OKAY;
        end
      end
      S_WAIT: begin
        HREADY = 1'b0;
        wcnt_n = wcnt - 4'd1;
        if (wcnt == 4'd0) state_n = S_OKAY;
      end
      S_ERR1: begin
        HREADY  = 1'b0;
        HRESP   = ERROR;
        state_n = S_ERR2;
      end
      default: state_n = S_OKAY;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= BYTE;
    end else if (HREADY) begin
      valid_q <= xfer;
      if (xfer) begin
        addr_q  <= HADDR[AW+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  // HREADY=1 with HRESP=OKAY only happens in S_OKAY: the completing data-phase edge.
  assign we = (state == S_OKAY) && valid_q && write_q;
  assign be = byte_lanes(size_q, addr_q[1:0]);

  ahb_sram_array #(.DEPTH(MEMDEPTH)) u_array (
    .clk   (HCLK),
    .we    (we),
    .be    (be),
    .addr  (addr_q[AW+1:2]),
    .wdata (HWDATA[31:0]),
    .rdata (mem_rdata)
  );

  assign HRDATA = ((state == S_OKAY) && valid_q && !write_q) ? mem_rdata : '0;

endmodule
